// File: rtl/apple_placer_pkg.sv
// apple_placer_pkg: shared defaults and FSM state encoding for the apple placer
package apple_placer_pkg;
    localparam int          DEF_LFSR_W    = 16;
    localparam logic [15:0] DEF_TAPS      = 16'hB400;
    localparam logic [15:0] DEF_SEED      = 16'hACE1;
    localparam int          DEF_GRID_W    = 40;
    localparam int          DEF_GRID_H    = 30;
    localparam int          DEF_X_W       = 8;
    localparam int          DEF_Y_W       = 7;
    localparam int          DEF_MAX_TRIES = 32;
    typedef enum logic [2:0] {
        S_IDLE, S_DRAW, S_QUERY, S_WAIT, S_SCAN_Q, S_SCAN_W, S_DONE, S_FAIL
    } state_t;
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: free-running shift-left Fibonacci LFSR with zero-lock guard and seed load
module lfsr_core #(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state
);
    // load beats the step; an all-zero state or zero load value falls back to SEED
    always_ff @(posedge clk)
        if (rst) state <= SEED;
        else if (load) state <= (load_val == '0) ? SEED : load_val;
        else if (state == '0) state <= SEED;
        else if (step) state <= {state[LFSR_W-2:0], ^(state & TAPS)};
endmodule

// File: rtl/apple_placer.sv
// apple_placer: random apple placement with occupancy query and scan fallback (option APPLE_PLACER_SEED_LOAD_EN)
module apple_placer
    import apple_placer_pkg::*;
#(
    parameter int                LFSR_W    = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS      = DEF_TAPS,
    parameter logic [LFSR_W-1:0] SEED      = DEF_SEED,
    parameter int                GRID_W    = DEF_GRID_W,
    parameter int                GRID_H    = DEF_GRID_H,
    parameter int                X_W       = DEF_X_W,
    parameter int                Y_W       = DEF_Y_W,
    parameter int                MAX_TRIES = DEF_MAX_TRIES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              busy,
    output logic              apple_valid,
    output logic              apple_fail,
    output logic [X_W-1:0]    ax,
    output logic [Y_W-1:0]    ay,
    output logic              occ_qry_valid,
    input  logic              occ_qry_ready,
    output logic [X_W-1:0]    occ_qry_x,
    output logic [Y_W-1:0]    occ_qry_y,
    input  logic              occ_rsp_valid,
    input  logic              occ_rsp_hit
`ifdef APPLE_PLACER_SEED_LOAD_EN
    ,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in
`endif
);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int SC_W  = $clog2(CELLS + 1);
    localparam int T_W   = $clog2(MAX_TRIES + 1);

    state_t                 state, nxt;
    logic [LFSR_W-1:0]      lfsr;
    logic                   load;
    logic [LFSR_W-1:0]      load_val;
    logic [X_W+Y_W-1:0]     cand;
    logic [X_W-1:0]         cand_x, cx;
    logic [Y_W-1:0]         cand_y, cy;
    logic [T_W-1:0]         tries;
    logic [SC_W-1:0]        scnt;
    logic                   in_range, last_try, last_cell, x_end, rsp_hit, rsp_miss;

`ifdef APPLE_PLACER_SEED_LOAD_EN
    assign load     = seed_load;
    assign load_val = seed_in;
`else
    assign load     = 1'b0;
    assign load_val = '0;
`endif

    lfsr_core #(.LFSR_W(LFSR_W), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
        .clk(clk), .rst(rst), .step(1'b1), .load(load), .load_val(load_val), .state(lfsr)
    );

    assign cand            = (X_W + Y_W)'(lfsr);
    assign {cand_y, cand_x} = cand;
    assign in_range  = (int'(cand_x) < GRID_W) && (int'(cand_y) < GRID_H);
    assign last_try  = tries == T_W'(MAX_TRIES - 1);
    assign last_cell = scnt == SC_W'(CELLS - 1);
    assign x_end     = int'(cx) == GRID_W - 1;
    assign rsp_hit   = occ_rsp_valid && occ_rsp_hit;
    assign rsp_miss  = occ_rsp_valid && !occ_rsp_hit;

    assign busy          = state != S_IDLE;
    assign apple_valid   = state == S_DONE;
    assign apple_fail    = state == S_FAIL;
    assign occ_qry_valid = (state == S_QUERY) || (state == S_SCAN_Q);
    assign occ_qry_x     = cx;
    assign occ_qry_y     = cy;

    // next-state logic: random draws until a free cell or the try budget runs out, then scan
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = req ? S_DRAW : S_IDLE;
            S_DRAW:   nxt = in_range ? S_QUERY : last_try ? S_SCAN_Q : S_DRAW;
            S_QUERY:  nxt = occ_qry_ready ? S_WAIT : S_QUERY;
            S_WAIT:   nxt = rsp_miss ? S_DONE : !rsp_hit ? S_WAIT : last_try ? S_SCAN_Q : S_DRAW;
            S_SCAN_Q: nxt = occ_qry_ready ? S_SCAN_W : S_SCAN_Q;
            S_SCAN_W: nxt = rsp_miss ? S_DONE : !rsp_hit ? S_SCAN_W : last_cell ? S_FAIL : S_SCAN_Q;
            default:  nxt = S_IDLE;
        endcase
    end

    // state register plus candidate/cursor, try and scan counters, and the delivered apple
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cx    <= '0;
            cy    <= '0;
            tries <= '0;
            scnt  <= '0;
            ax    <= '0;
            ay    <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE) tries <= '0;
            if (state == S_DRAW) begin
                cx <= cand_x;
                cy <= cand_y;
                if (!in_range) tries <= tries + 1'b1;
            end
            if (state == S_WAIT && rsp_hit) tries <= tries + 1'b1;
            if (nxt == S_SCAN_Q && (state == S_DRAW || state == S_WAIT)) begin
                cx   <= '0;
                cy   <= '0;
                scnt <= '0;
            end
            if (state == S_SCAN_W && rsp_hit) begin
                scnt <= scnt + 1'b1;
                cx   <= x_end ? '0 : cx + 1'b1;
                cy   <= x_end ? cy + 1'b1 : cy;
            end
            if (nxt == S_DONE) begin
                ax <= cx;
                ay <= cy;
            end
        end
    end
endmodule

// File: tb/tb_apple_placer.sv
// tb_apple_placer: scoreboard bench for apple_placer on a 40x30 grid and a 256x128 grid
module tb_apple_placer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    logic        seed_load = 1'b0;
    logic [15:0] seed_in   = 16'h0;

    logic       req_m = 1'b0, busy_m, av_m, af_m, qv_m, rdy_m, rv_m, rh_m;
    logic [7:0] ax_m, qx_m;
    logic [6:0] ay_m, qy_m;

    logic       req_b = 1'b0, busy_b, av_b, af_b, qv_b, rv_b;
    logic       rh_b = 1'b0;
    logic [7:0] ax_b, qx_b;
    logic [6:0] ay_b, qy_b;

    apple_placer u_main (
        .clk(clk), .rst(rst), .req(req_m), .busy(busy_m), .apple_valid(av_m), .apple_fail(af_m),
        .ax(ax_m), .ay(ay_m), .occ_qry_valid(qv_m), .occ_qry_ready(rdy_m), .occ_qry_x(qx_m),
        .occ_qry_y(qy_m), .occ_rsp_valid(rv_m), .occ_rsp_hit(rh_m)
`ifdef APPLE_PLACER_SEED_LOAD_EN
        , .seed_load(seed_load), .seed_in(seed_in)
`endif
    );

    apple_placer #(.GRID_W(256), .GRID_H(128)) u_big (
        .clk(clk), .rst(rst), .req(req_b), .busy(busy_b), .apple_valid(av_b), .apple_fail(af_b),
        .ax(ax_b), .ay(ay_b), .occ_qry_valid(qv_b), .occ_qry_ready(1'b1), .occ_qry_x(qx_b),
        .occ_qry_y(qy_b), .occ_rsp_valid(rv_b), .occ_rsp_hit(rh_b)
`ifdef APPLE_PLACER_SEED_LOAD_EN
        , .seed_load(seed_load), .seed_in(seed_in)
`endif
    );

    // golden LFSR: x^16+x^14+x^13+x^11, shift left, zero reloads ACE1
    function automatic logic [15:0] lstep(input logic [15:0] v);
        return (v == 16'h0) ? 16'hACE1 : {v[14:0], ^(v & 16'hB400)};
    endfunction

    logic [15:0] gold;
    always @(posedge clk)
        if (rst) gold <= 16'hACE1;
`ifdef APPLE_PLACER_SEED_LOAD_EN
        else if (seed_load) gold <= (seed_in == 16'h0) ? 16'hACE1 : seed_in;
`endif
        else gold <= lstep(gold);

    // big-grid checker: always ready, always free, response one cycle after accept
    always @(posedge clk) rv_b <= !rst && qv_b;

    // main checker: random ready, 1..3 cycle response, occupancy chosen by mode
    int         mode = 0;
    int         nq = 0;
    int         dly = 0;
    logic       pend = 1'b0;
    logic [7:0] px = 8'h0;
    logic [6:0] py = 7'h0;
    always @(posedge clk) begin
        if (rst) begin
            pend  <= 1'b0;
            rv_m  <= 1'b0;
            rh_m  <= 1'b0;
            rdy_m <= 1'b0;
        end else begin
            rdy_m <= ($urandom_range(0, 3) != 0);
            rv_m  <= 1'b0;
            if (pend) begin
                if (dly == 0) begin
                    rv_m <= 1'b1;
                    rh_m <= (mode == 2) || (mode == 1 && !(px == 8'd5 && py == 7'd3));
                    pend <= 1'b0;
                end else dly <= dly - 1;
            end else if (qv_m && rdy_m) begin
                pend <= 1'b1;
                px   <= qx_m;
                py   <= qy_m;
                dly  <= $urandom_range(0, 2);
                nq   <= nq + 1;
                chk("query_in_grid", {31'h0, (qx_m < 8'd40) && (qy_m < 7'd30)}, 1);
            end
        end
    end

    // kind: 0 exact x/y and cycle, 1 exact x/y, 2 in-grid, 3 fail with held x/y
    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [31:0] cyc;
    } exp_t;
    exp_t qb[$];
    exp_t qm[$];
    exp_t eb, em;
    int pulses_m = 0;
    int pulses_b = 0;

    always @(negedge clk) begin
        if (!rst && (av_b || af_b)) begin
            pulses_b++;
            if (qb.size() == 0) chk("big_unexpected_pulse", {30'h0, av_b, af_b}, 0);
            else begin
                eb = qb.pop_front();
                chk("big_valid", {31'h0, av_b}, 1);
                chk("big_ax", {24'h0, ax_b}, {24'h0, eb.x});
                chk("big_ay", {25'h0, ay_b}, {25'h0, eb.y});
                chk("big_latency_cycle", cyc, eb.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (av_m || af_m)) begin
            pulses_m++;
            if (qm.size() == 0) chk("main_unexpected_pulse", {30'h0, av_m, af_m}, 0);
            else begin
                em = qm.pop_front();
                chk("main_valid", {31'h0, av_m}, (em.kind == 2'd3) ? 0 : 1);
                chk("main_fail", {31'h0, af_m}, (em.kind == 2'd3) ? 1 : 0);
                if (em.kind == 2'd2) begin
                    chk("main_ax_lt40", {31'h0, ax_m < 8'd40}, 1);
                    chk("main_ay_lt30", {31'h0, ay_m < 7'd30}, 1);
                end else begin
                    chk("main_ax", {24'h0, ax_m}, {24'h0, em.x});
                    chk("main_ay", {25'h0, ay_m}, {25'h0, em.y});
                end
            end
        end
    end

    task automatic req_pulse_m();
        @(posedge clk);
        #1 req_m = 1'b1;
        @(posedge clk);
        #1 req_m = 1'b0;
    endtask

    task automatic wait_pulse_m(input int n0, input int lim, input string nm);
        int k = 0;
        while (pulses_m == n0 && k < lim) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(nm, {31'h0, pulses_m != n0}, 1);
    endtask

    task automatic big_req();
        logic [15:0] g;
        @(posedge clk);
        #1;
        g = lstep(gold);
        qb.push_back('{kind: 2'd0, x: g[7:0], y: g[14:8], cyc: cyc + 4});
        req_b = 1'b1;
        @(posedge clk);
        #1 req_b = 1'b0;
        repeat (5 + $urandom_range(0, 3)) @(posedge clk);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n0, q0, k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_lfsr", {16'h0, u_main.lfsr}, 32'hACE1);
        chk("rst_busy", {31'h0, busy_m}, 0);
        chk("rst_valid_fail", {30'h0, av_m, af_m}, 0);
        chk("rst_ax_ay", {17'h0, ax_m, ay_m}, 0);
        chk("rst_qry_valid", {31'h0, qv_m}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("lfsr_track", {16'h0, u_main.lfsr}, {16'h0, gold});
        end

        for (int i = 0; i < 8; i++) big_req();
        chk("big_pulse_count", pulses_b, 8);

`ifdef APPLE_PLACER_SEED_LOAD_EN
        @(posedge clk);
        #1;
        seed_in   = 16'h1234;
        seed_load = 1'b1;
        req_b     = 1'b1;
        qb.push_back('{kind: 2'd0, x: 8'h34, y: 7'h12, cyc: cyc + 4});
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        req_b     = 1'b0;
        repeat (6) @(posedge clk);
        chk("seed_pulse_count", pulses_b, 9);
`endif

        mode = 0;
        for (int i = 0; i < 1000; i++) begin
            n0 = pulses_m;
            qm.push_back('{kind: 2'd2, x: 8'h0, y: 7'h0, cyc: 0});
            req_pulse_m();
            wait_pulse_m(n0, 500, "range_req_done");
        end

        mode = 1;
        n0 = pulses_m;
        qm.push_back('{kind: 2'd1, x: 8'd5, y: 7'd3, cyc: 0});
        req_pulse_m();
        wait_pulse_m(n0, 3000, "only_free_cell_done");

        mode = 2;
        n0 = pulses_m;
        q0 = nq;
        qm.push_back('{kind: 2'd3, x: 8'd5, y: 7'd3, cyc: 0});
        req_pulse_m();
        wait_pulse_m(n0, 12000, "full_grid_fail_done");
        chk("full_grid_query_count", {31'h0, (nq - q0 >= 1200) && (nq - q0 <= 1232)}, 1);
        @(negedge clk);
        chk("busy_after_fail", {31'h0, busy_m}, 0);

        mode = 0;
        n0 = pulses_m;
        req_pulse_m();
        k = 0;
        @(negedge clk);
        while (!(qv_m && rdy_m) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("rst_test_accept_seen", {31'h0, qv_m && rdy_m}, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("busy_after_abort", {31'h0, busy_m}, 0);
        chk("qry_after_abort", {31'h0, qv_m}, 0);
        repeat (20) @(negedge clk);
        chk("no_pulse_after_abort", pulses_m, n0);

        n0 = pulses_m;
        qm.push_back('{kind: 2'd2, x: 8'h0, y: 7'h0, cyc: 0});
        req_pulse_m();
        @(negedge clk);
        chk("busy_next_cycle", {31'h0, busy_m}, 1);
        req_m = 1'b1;
        @(posedge clk);
        #1 req_m = 1'b0;
        wait_pulse_m(n0, 500, "busy_req_done");
        repeat (30) @(negedge clk);
        chk("req_while_busy_ignored", pulses_m, n0 + 1);
        chk("main_queue_drained", qm.size(), 0);
        chk("big_queue_drained", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
